irq_pending_unit: RTL

- Interrupt capture stage directly upstream of the core's exception controller.
- Synchronizes external interrupt sources, detects edges or samples levels per line, and holds pending state.
- Applies a mask and drives the level-triggered 32-bit irq line vector the exception controller consumes.
- Clears edge-mode pending bits when the exception controller reports it has saved an interrupt cause. Software configures it through a small register port.

---
 rtl/irq_pending_unit_pkg.sv | 44 ++++
 rtl/irq_pending_unit_sync_edge.sv | 48 ++++
 rtl/irq_pending_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/irq_pending_unit_pkg.sv
// -----------------------------------------------------------------------------
// irq_pending_unit_pkg
//
// Purpose : Shared constants for the interrupt pending unit. This covers the
//           register word indices, the layout of the cause field reported by
//           the exception controller, and a helper that decodes an
//           acknowledge for one line.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package irq_pending_unit_pkg;

  // Width of the irq vector handed to the exception controller.
  localparam int unsigned IRQ_VEC_W = 32;

  // Register port word indices.
  localparam int unsigned IRQ_REG_AW       = 3;
  localparam logic [2:0]  IRQ_REG_PENDING  = 3'd0;
  localparam logic [2:0]  IRQ_REG_MASK     = 3'd1;
  localparam logic [2:0]  IRQ_REG_EDGE_SEL = 3'd2;
  localparam logic [2:0]  IRQ_REG_SET      = 3'd3;
  localparam logic [2:0]  IRQ_REG_CLR      = 3'd4;

  // Committed-cause field layout.
  localparam int unsigned CAUSE_W       = 6;
  localparam int unsigned CAUSE_IRQ_BIT = 5;
  localparam int unsigned CAUSE_ID_MSB  = 4;
  localparam int unsigned CAUSE_ID_LSB  = 0;

  // True when the exception controller has just saved an interrupt cause
  // whose id names this line. Synchronous exceptions (flag bit clear) never
  // match. The caller only asks about lines that exist, so ids beyond
  // NUM_IRQ have no line to hit.
  function automatic logic cause_acks_line(
    input logic               save,
    input logic [CAUSE_W-1:0] cause,
    input int unsigned        line
  );
    logic [CAUSE_ID_MSB:CAUSE_ID_LSB] line_id;
    line_id = 5'(line);
    return save & cause[CAUSE_IRQ_BIT] &
           (cause[CAUSE_ID_MSB:CAUSE_ID_LSB] == line_id);
  endfunction

endpackage : irq_pending_unit_pkg

// File: rtl/irq_pending_unit_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
//
// Purpose : A synchronizer and rising-edge detector for one interrupt line.
//           The line is sampled by a chain of SYNC_STAGES flops. The last
//           stage is also registered once more, so that a rising edge can be
//           flagged.
// Ports   :
//   clk     in   core clock
//   rst_n   in   synchronous active-low reset
//   src_i   in   asynchronous interrupt source
//   sync_o  out  synchronized level (last synchronizer stage)
//   rise_o  out  one-cycle pulse when sync_o goes from 0 to 1
// -----------------------------------------------------------------------------
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], src_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : irq_sync_edge

// File: rtl/irq_pending_unit.sv
// -----------------------------------------------------------------------------
// irq_pending_unit
//
// Purpose : The interrupt capture stage that feeds the exception controller.
//           Each source is synchronized, then either edge-captured or
//           level-followed into PENDING. The result is masked and presented
//           as a 32-bit level vector. When the controller saves an
//           interrupt cause, the matching edge-mode pending bit is cleared.
//           Software reaches PENDING, MASK, EDGE_SEL, SET and CLR through a
//           small word-indexed register port.
// Ports   :
//   clk           in   core clock
//   rst_n         in   synchronous active-low reset
//   irq_src_i     in   [NUM_IRQ] asynchronous interrupt sources
//   irq_o         out  [32] PENDING & MASK; bits >= NUM_IRQ are 0
//   save_cause_i  in   controller committed a cause this cycle
//   cause_i       in   [6] bit5 = interrupt flag, [4:0] = line id
//   reg_req_i     in   register access valid
//   reg_we_i      in   1 = write, 0 = read
//   reg_addr_i    in   [3] word index
//   reg_wdata_i   in   [32] write data
//   reg_rdata_o   out  [32] read data, one cycle after the request
//   reg_rvalid_o  out  read-data valid strobe
// -----------------------------------------------------------------------------
module irq_pending_unit
  import irq_pending_unit_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_IRQ-1:0]    irq_src_i,
  output logic [IRQ_VEC_W-1:0]  irq_o,
  input  logic                  save_cause_i,
  input  logic [CAUSE_W-1:0]    cause_i,
  input  logic                  reg_req_i,
  input  logic                  reg_we_i,
  input  logic [IRQ_REG_AW-1:0] reg_addr_i,
  input  logic [IRQ_VEC_W-1:0]  reg_wdata_i,
  output logic [IRQ_VEC_W-1:0]  reg_rdata_o,
  output logic                  reg_rvalid_o
);

  // Per-line synchronized level and rising-edge pulse.
  logic [NUM_IRQ-1:0] sync;
  logic [NUM_IRQ-1:0] rise;

  // Configuration and pending state.
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;

  // Per-cycle set/clear requests.
  logic [NUM_IRQ-1:0] sw_set;
  logic [NUM_IRQ-1:0] sw_clr;
  logic [NUM_IRQ-1:0] ack_hit;
  logic [NUM_IRQ-1:0] set_any;
  logic [NUM_IRQ-1:0] clr_any;

  // A level-mode line reads straight from its synchronizer, so that level
  // latency is only SYNC_STAGES. An edge-mode line reads its held flop.
  logic [NUM_IRQ-1:0] pending_view;

  // Registers zero-extended to the full 32-bit word.
  logic [IRQ_VEC_W-1:0] pending_word;
  logic [IRQ_VEC_W-1:0] mask_word;
  logic [IRQ_VEC_W-1:0] edge_sel_word;

  // Read response.
  logic [IRQ_VEC_W-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;

  logic reg_wr;
  logic reg_rd;

  assign reg_wr = reg_req_i & reg_we_i;
  assign reg_rd = reg_req_i & ~reg_we_i;

  // ---------------------------------------------------------------------------
  // Per-line synchronizer, edge detector and acknowledge decode
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .src_i  (irq_src_i[gi]),
      .sync_o (sync[gi]),
      .rise_o (rise[gi])
    );

    assign ack_hit[gi] = cause_acks_line(save_cause_i, cause_i, gi);
  end

  // ---------------------------------------------------------------------------
  // Widen the line-sized registers to the 32-bit bus. Unused lines stay 0.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < IRQ_VEC_W; gi++) begin : g_word
    if (gi < NUM_IRQ) begin : g_live
      assign pending_word[gi]  = pending_view[gi];
      assign mask_word[gi]     = mask_q[gi];
      assign edge_sel_word[gi] = edge_sel_q[gi];
    end else begin : g_tied
      assign pending_word[gi]  = 1'b0;
      assign mask_word[gi]     = 1'b0;
      assign edge_sel_word[gi] = 1'b0;
    end
  end

  assign pending_view = (pending_q & edge_sel_q) | (sync & ~edge_sel_q);
  assign irq_o        = pending_word & mask_word;

  // ---------------------------------------------------------------------------
  // Register writes: MASK/EDGE_SEL updates and SET/CLR strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    mask_d     = mask_q;
    edge_sel_d = edge_sel_q;
    sw_set     = '0;
    sw_clr     = '0;
    if (reg_wr) begin
      case (reg_addr_i)
        IRQ_REG_MASK:     mask_d     = reg_wdata_i[NUM_IRQ-1:0];
        IRQ_REG_EDGE_SEL: edge_sel_d = reg_wdata_i[NUM_IRQ-1:0];
        IRQ_REG_SET:      sw_set     = reg_wdata_i[NUM_IRQ-1:0];
        IRQ_REG_CLR:      sw_clr     = reg_wdata_i[NUM_IRQ-1:0];
        default:          ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pending next state
  // ---------------------------------------------------------------------------
  // For an edge-mode line, set beats clear, so that an edge arriving in the
  // same cycle as its ack is kept. For a level-mode line, the flop just
  // shadows sync. This means a level->edge switch starts from the level that
  // was visible, and an edge->level switch is immediate through pending_view.
  always_comb begin
    set_any   = rise | sw_set;
    clr_any   = sw_clr | ack_hit;
    pending_d = (edge_sel_q & (set_any | (pending_q & ~clr_any))) |
                (~edge_sel_q & sync);
  end

  // ---------------------------------------------------------------------------
  // Read path: sample at the request edge, return 0 when there is no read.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_d  = '0;
    rvalid_d = reg_rd;
    if (reg_rd) begin
      case (reg_addr_i)
        IRQ_REG_PENDING:  rdata_d = pending_word;
        IRQ_REG_MASK:     rdata_d = mask_word;
        IRQ_REG_EDGE_SEL: rdata_d = edge_sel_word;
        default:          rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q  <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign reg_rdata_o  = rdata_q;
  assign reg_rvalid_o = rvalid_q;

endmodule : irq_pending_unit
